// File: rtl/ad5300_dac_tx.sv
// ad5300_dac_tx
//   Serial transmitter for an AD5300 8-bit DAC. A write offered on the
//   load_* handshake becomes one 16-bit frame {00, pd[1:0], data[7:0], 0000}.
//   The frame is shifted MSB-first on sync_n/dac_sclk/dac_din, and the DAC
//   samples dac_din on falling edges of dac_sclk. After each frame, sync_n
//   is held high for a guard gap before the next write is accepted.
//
// Ports
//   sclk        system clock (all logic on rising edge)
//   rstn        async active-low reset
//   load_valid  write offered
//   load_ready  block can accept a write
//   load_data   8-bit DAC code
//   load_pd     power-down mode (00 normal, 01 1k, 10 100k, 11 three-state)
//   sync_n      DAC SYNC, low for the whole frame
//   dac_sclk    DAC serial clock, idles high
//   dac_din     DAC serial data, MSB first
//   busy        high from acceptance until the gap expires
//   done        one-cycle pulse as sync_n rises at the end of a full frame
module ad5300_dac_tx #(
  parameter int SYSCLK_FREQ = 100_000_000,
  parameter int SCLK_DIV    = 4,
  parameter int IDLE_CYCLES = 100
) (
  input  logic       sclk,
  input  logic       rstn,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [7:0] load_data,
  input  logic [1:0] load_pd,
  output logic       sync_n,
  output logic       dac_sclk,
  output logic       dac_din,
  output logic       busy,
  output logic       done
);

  localparam int DW = $clog2(SCLK_DIV + 1);
  localparam int GW = $clog2(IDLE_CYCLES + 1);
  // Resulting serial clock rate; the AD5300 tops out at 30 MHz.
  localparam int DAC_SCLK_HZ = SYSCLK_FREQ / (2 * SCLK_DIV);

  localparam logic [DW-1:0] DIV_LOAD = DW'(SCLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(IDLE_CYCLES - 1);

  if (SCLK_DIV < 1) begin : gBadDiv
    $error("ad5300_dac_tx: SCLK_DIV must be >= 1");
  end
  if (IDLE_CYCLES < 1) begin : gBadGap
    $error("ad5300_dac_tx: IDLE_CYCLES must be >= 1");
  end
  if (DAC_SCLK_HZ > 30_000_000) begin : gTooFast
    $error("ad5300_dac_tx: dac_sclk exceeds 30 MHz");
  end

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, GAP
  } dacState_t;

  dacState_t       state, stateNxt;
  logic [DW-1:0]   divCnt, divNxt;
  logic [GW-1:0]   gapCnt, gapNxt;
  logic [3:0]      bitCnt, bitNxt;
  logic [15:0]     shiftReg, shiftNxt;
  logic            syncNxt, sclkNxt, dinNxt, readyNxt, busyNxt, doneNxt;
  logic            divLast;

  assign divLast = (divCnt == '0);

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      divCnt     <= '0;
      gapCnt     <= '0;
      bitCnt     <= '0;
      shiftReg   <= '0;
      sync_n     <= 1'b1;
      dac_sclk   <= 1'b1;
      dac_din    <= 1'b0;
      load_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= stateNxt;
      divCnt     <= divNxt;
      gapCnt     <= gapNxt;
      bitCnt     <= bitNxt;
      shiftReg   <= shiftNxt;
      sync_n     <= syncNxt;
      dac_sclk   <= sclkNxt;
      dac_din    <= dinNxt;
      load_ready <= readyNxt;
      busy       <= busyNxt;
      done       <= doneNxt;
    end
  end

  // Every output is registered, so this block computes the value each
  // output takes after the coming edge, alongside the state transition.
  always_comb begin
    stateNxt = state;
    divNxt   = divCnt;
    gapNxt   = gapCnt;
    bitNxt   = bitCnt;
    shiftNxt = shiftReg;
    syncNxt  = sync_n;
    sclkNxt  = dac_sclk;
    dinNxt   = dac_din;
    readyNxt = load_ready;
    busyNxt  = busy;
    doneNxt  = 1'b0;

    unique case (state)
      IDLE: begin
        // load_ready comes up one cycle after reset release and stays up.
        readyNxt = 1'b1;
        busyNxt  = 1'b0;
        syncNxt  = 1'b1;
        sclkNxt  = 1'b1;
        dinNxt   = 1'b0;
        if (load_valid && load_ready) begin
          stateNxt = SETUP;
          shiftNxt = {2'b00, load_pd, load_data, 4'b0000};
          divNxt   = DIV_LOAD;
          bitNxt   = '0;
          readyNxt = 1'b0;
          busyNxt  = 1'b1;
          syncNxt  = 1'b0;
          dinNxt   = shiftNxt[15];
        end
      end

      SETUP: begin
        if (divLast) begin
          stateNxt = SHIFT_LO;
          sclkNxt  = 1'b0;
          divNxt   = DIV_LOAD;
        end else begin
          divNxt = divCnt - DW'(1);
        end
      end

      SHIFT_LO: begin
        if (divLast) begin
          sclkNxt = 1'b1;
          divNxt  = DIV_LOAD;
          // bitCnt counts completed low phases; stopping at 15 means it
          // never wraps and never produces a 17th falling edge.
          if (bitCnt == 4'd15) begin
            stateNxt = HOLD;
          end else begin
            stateNxt = SHIFT_HI;
            bitNxt   = bitCnt + 4'd1;
            shiftNxt = {shiftReg[14:0], 1'b0};
            dinNxt   = shiftReg[14];
          end
        end else begin
          divNxt = divCnt - DW'(1);
        end
      end

      SHIFT_HI: begin
        if (divLast) begin
          stateNxt = SHIFT_LO;
          sclkNxt  = 1'b0;
          divNxt   = DIV_LOAD;
        end else begin
          divNxt = divCnt - DW'(1);
        end
      end

      HOLD: begin
        if (divLast) begin
          stateNxt = GAP;
          syncNxt  = 1'b1;
          doneNxt  = 1'b1;
          dinNxt   = 1'b0;
          gapNxt   = GAP_LOAD;
        end else begin
          divNxt = divCnt - DW'(1);
        end
      end

      GAP: begin
        if (gapCnt == '0) begin
          stateNxt = IDLE;
          readyNxt = 1'b1;
          busyNxt  = 1'b0;
        end else begin
          gapNxt = gapCnt - GW'(1);
        end
      end

      default: stateNxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ad5300_dac_tx.sv
// Directed bench for ad5300_dac_tx. Instance A uses the default rates
// (SCLK_DIV=4, IDLE_CYCLES=100); instance B is the SCLK_DIV=1/IDLE_CYCLES=1
// corner. A per-instance monitor, sampled on the falling system clock edge,
// rebuilds each frame from dac_din at dac_sclk falling edges and records
// frame length, edge count, done pulses, gap length and data stability.
module tb_ad5300_dac_tx;

  logic sclk;
  logic rstn;

  logic       vldA, rdyA, syncA, dsclkA, dinA, busyA, doneA;
  logic [7:0] dataA;
  logic [1:0] pdA;
  logic       vldB, rdyB, syncB, dsclkB, dinB, busyB, doneB;
  logic [7:0] dataB;
  logic [1:0] pdB;

  ad5300_dac_tx #(.SYSCLK_FREQ(100_000_000), .SCLK_DIV(4), .IDLE_CYCLES(100)) dutA (
    .sclk(sclk), .rstn(rstn), .load_valid(vldA), .load_ready(rdyA),
    .load_data(dataA), .load_pd(pdA), .sync_n(syncA), .dac_sclk(dsclkA),
    .dac_din(dinA), .busy(busyA), .done(doneA)
  );

  ad5300_dac_tx #(.SYSCLK_FREQ(100_000_000), .SCLK_DIV(1), .IDLE_CYCLES(1)) dutB (
    .sclk(sclk), .rstn(rstn), .load_valid(vldB), .load_ready(rdyB),
    .load_data(dataB), .load_pd(pdB), .sync_n(syncB), .dac_sclk(dsclkB),
    .dac_din(dinB), .busy(busyB), .done(doneB)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int nTests = 0;
  int nFail  = 0;
  int cyc    = 0;

  // monitor state, index 0 = A, 1 = B
  int          divOf[2];
  logic        prevSync[2], prevSclk[2], prevDin[2], prevRdy[2];
  logic [15:0] cap[2], lastFrame[2];
  int          falls[2], lastFalls[2], lowCnt[2], lastLow[2];
  int          doneCnt[2], doneCyc[2], riseCyc[2], fallCyc[2], fallSpacing[2];
  int          readyRiseCyc[2], stable[2], sinceFall[2], stabErr[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int k, input logic s, input logic sc, input logic d,
                     input logic r, input logic dn);
    if (d !== prevDin[k]) stable[k] = 1; else stable[k]++;
    sinceFall[k]++;
    if (prevSync[k] && !s) begin
      cap[k] = '0; falls[k] = 0; lowCnt[k] = 0;
      fallSpacing[k] = cyc - fallCyc[k];
      fallCyc[k] = cyc;
    end
    if (!s) lowCnt[k]++;
    if (!prevSync[k] && s) begin
      riseCyc[k] = cyc; lastFrame[k] = cap[k];
      lastFalls[k] = falls[k]; lastLow[k] = lowCnt[k];
    end
    if (prevSclk[k] && !sc && !s) begin
      cap[k] = {cap[k][14:0], d};
      falls[k]++;
      // din must have been held for SCLK_DIV full cycles before the edge
      if (stable[k] < divOf[k] + 1) stabErr[k]++;
      sinceFall[k] = 0;
    end else if ((d !== prevDin[k]) && (sinceFall[k] < divOf[k])) begin
      stabErr[k]++;
    end
    if (dn) begin doneCnt[k]++; doneCyc[k] = cyc; end
    if (!prevRdy[k] && r) readyRiseCyc[k] = cyc;
    prevSync[k] = s; prevSclk[k] = sc; prevDin[k] = d; prevRdy[k] = r;
  endtask

  task automatic tick();
    @(negedge sclk);
    cyc++;
    mon(0, syncA, dsclkA, dinA, rdyA, doneA);
    mon(1, syncB, dsclkB, dinB, rdyB, doneB);
  endtask

  task automatic waitRdy(input int k, input int budget, input string tag);
    int n = 0;
    while (((k == 0) ? rdyA : rdyB) !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < budget), 32'd1);
  endtask

  initial begin
    int f1;
    int n;
    divOf[0] = 4; divOf[1] = 1;
    for (int k = 0; k < 2; k++) begin
      prevSync[k] = 1'b1; prevSclk[k] = 1'b1; prevDin[k] = 1'b0; prevRdy[k] = 1'b0;
      cap[k] = '0; lastFrame[k] = '0; falls[k] = 0; lastFalls[k] = 0;
      lowCnt[k] = 0; lastLow[k] = 0; doneCnt[k] = 0; doneCyc[k] = 0;
      riseCyc[k] = 0; fallCyc[k] = 0; fallSpacing[k] = 0; readyRiseCyc[k] = 0;
      stable[k] = 0; sinceFall[k] = 1000; stabErr[k] = 0;
    end
    rstn = 1'b0;
    vldA = 1'b0; dataA = 8'h00; pdA = 2'b00;
    vldB = 1'b0; dataB = 8'h00; pdB = 2'b00;

    // reset values
    repeat (3) tick();
    chk("rst_sync_n", syncA, 1);
    chk("rst_dac_sclk", dsclkA, 1);
    chk("rst_dac_din", dinA, 0);
    chk("rst_ready", rdyA, 0);
    chk("rst_busy", busyA, 0);
    chk("rst_done", doneA, 0);
    chk("rst_readyB", rdyB, 0);
    rstn = 1'b1;
    tick();
    chk("ready_after_release", rdyA, 1);
    chk("ready_after_releaseB", rdyB, 1);

    // single write 0xA5, pd 00
    dataA = 8'hA5; pdA = 2'b00; vldA = 1'b1;
    tick();
    vldA = 1'b0; dataA = 8'h3C; pdA = 2'b10;   // must not disturb the frame
    chk("w1_sync_fall", syncA, 0);
    chk("w1_busy", busyA, 1);
    chk("w1_ready_drop", rdyA, 0);
    doneCnt[0] = 0; stabErr[0] = 0;
    waitRdy(0, 1000, "w1");
    chk("w1_frame", lastFrame[0], 16'h0A50);
    chk("w1_falls", lastFalls[0], 16);
    chk("w1_sync_low", lastLow[0], 132);
    chk("w1_done_cnt", doneCnt[0], 1);
    chk("w1_done_at_rise", 32'(doneCyc[0] == riseCyc[0]), 1);
    chk("w1_gap", readyRiseCyc[0] - riseCyc[0], 100);
    chk("w1_stable", stabErr[0], 0);
    chk("w1_busy_idle", busyA, 0);

    // power-down write 0xFF, pd 11
    dataA = 8'hFF; pdA = 2'b11; vldA = 1'b1;
    tick();
    vldA = 1'b0; dataA = 8'h00; pdA = 2'b00;
    doneCnt[0] = 0; stabErr[0] = 0;
    waitRdy(0, 1000, "pd");
    chk("pd_frame", lastFrame[0], 16'h3FF0);
    chk("pd_falls", lastFalls[0], 16);
    chk("pd_stable", stabErr[0], 0);
    chk("pd_done_cnt", doneCnt[0], 1);

    // back-to-back with load_valid held high
    dataA = 8'h12; pdA = 2'b00; vldA = 1'b1;
    tick();
    f1 = fallCyc[0];
    doneCnt[0] = 0;
    repeat (20) tick();
    dataA = 8'h34;
    n = 0;
    while (fallCyc[0] == f1 && n < 400) begin tick(); n++; end
    chk("b2b_second_timeout", 32'(n < 400), 1);
    vldA = 1'b0;
    chk("b2b_frame1", lastFrame[0], 16'h0120);
    chk("b2b_spacing", fallSpacing[0], 233);
    chk("b2b_gap", readyRiseCyc[0] - riseCyc[0], 100);
    chk("b2b_done1", doneCnt[0], 1);
    waitRdy(0, 1000, "b2b2");
    chk("b2b_frame2", lastFrame[0], 16'h0340);
    chk("b2b_done2", doneCnt[0], 2);

    // abort after 7 falling edges
    dataA = 8'h5A; vldA = 1'b1;
    tick();
    vldA = 1'b0;
    doneCnt[0] = 0;
    n = 0;
    while (falls[0] != 7 && n < 300) begin tick(); n++; end
    chk("abort_reach7_timeout", 32'(n < 300), 1);
    chk("abort_pre_sclk", dsclkA, 0);
    rstn = 1'b0;
    #1;
    chk("abort_sync_n", syncA, 1);
    chk("abort_dac_sclk", dsclkA, 1);
    chk("abort_dac_din", dinA, 0);
    chk("abort_busy", busyA, 0);
    repeat (3) tick();
    chk("abort_no_done", doneCnt[0], 0);
    rstn = 1'b1;
    tick();
    chk("abort_ready_back", rdyA, 1);
    dataA = 8'h80; vldA = 1'b1;
    tick();
    vldA = 1'b0;
    doneCnt[0] = 0; stabErr[0] = 0;
    waitRdy(0, 1000, "post_abort");
    chk("post_abort_frame", lastFrame[0], 16'h0800);
    chk("post_abort_falls", lastFalls[0], 16);
    chk("post_abort_low", lastLow[0], 132);
    chk("post_abort_done", doneCnt[0], 1);
    chk("post_abort_stable", stabErr[0], 0);

    // corner instance: SCLK_DIV=1, IDLE_CYCLES=1
    dataB = 8'h01; pdB = 2'b00; vldB = 1'b1;
    tick();
    chk("cB_sync_fall", syncB, 0);
    chk("cB_busy", busyB, 1);
    f1 = fallCyc[1];
    doneCnt[1] = 0; stabErr[1] = 0;
    n = 0;
    while (fallCyc[1] == f1 && n < 200) begin tick(); n++; end
    chk("cB_second_timeout", 32'(n < 200), 1);
    vldB = 1'b0;
    chk("cB_frame", lastFrame[1], 16'h0010);
    chk("cB_sync_low", lastLow[1], 33);
    chk("cB_falls", lastFalls[1], 16);
    chk("cB_gap", readyRiseCyc[1] - riseCyc[1], 1);
    chk("cB_spacing", fallSpacing[1], 35);
    chk("cB_done", doneCnt[1], 1);
    waitRdy(1, 200, "cB_end");
    chk("cB_frame2", lastFrame[1], 16'h0010);
    chk("cB_stable", stabErr[1], 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/ad5300_dac_tx.md
Name: ad5300_dac_tx

Overview:
- Serial transmitter driving an AD5300 8-bit DAC, the write-side counterpart of the rover's 8-bit serial ADC reader.
- Accepts an 8-bit code and a 2-bit power-down mode over a valid/ready handshake.
- Shifts a 16-bit frame MSB-first on SYNC/SCLK/DIN, with data sampled by the DAC on SCLK falling edges.
- Sits between rover control logic (setpoints, analog references) and the board-level DAC pins.

Parameters:
- SYSCLK_FREQ, 100_000_000, system clock frequency in Hz. Informational only; used for derived-rate comments and assertions.
- SCLK_DIV, 4, system clocks per dac_sclk half-period. Must be ≥1. The default gives 12.5 MHz, below the AD5300 30 MHz limit.
- IDLE_CYCLES, 100, minimum system clocks sync_n stays high between frames. Must be ≥1.

Ports:
- sclk, input, 1, system clock. All logic is on the rising edge.
- rstn, input, 1, reset. Asynchronous, active-low.
- load_valid, input, 1, a new DAC write is offered.
- load_ready, output, 1, the block can accept a write.
- load_data, input, 8, DAC code.
- load_pd, input, 2, power-down mode: 00 normal, 01 1k to GND, 10 100k to GND, 11 three-state.
- sync_n, output, 1, DAC SYNC, active-low frame enable.
- dac_sclk, output, 1, DAC serial clock. Idles high.
- dac_din, output, 1, DAC serial data, MSB first.
- busy, output, 1, high from acceptance until the gap expires.
- done, output, 1, one-cycle pulse when a frame completes.

Behaviour:
- All outputs are registered.
- Reset values: sync_n=1, dac_sclk=1, dac_din=0, load_ready=0, busy=0, done=0. State is IDLE and all counters are cleared.
- load_ready asserts in the first cycle after rstn deasserts.
- Handshake:
  - A transfer occurs on a rising edge where load_valid && load_ready.
  - On acceptance, latch frame = {2'b00, load_pd, load_data, 4'b0000} into a 16-bit shift register.
  - load_ready drops and busy rises in the next cycle.
  - Input changes after acceptance have no effect on the frame in flight.
  - load_valid while load_ready=0 is ignored. Nothing is queued.
- States: IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, GAP.
  - IDLE: load_ready=1. On acceptance go to SETUP.
  - SETUP: sync_n=0, dac_sclk=1, dac_din=frame[15] for SCLK_DIV cycles. Then go to SHIFT_LO.
  - SHIFT_LO: dac_sclk=0 for SCLK_DIV cycles; the falling edge on entry is the DAC sample point. After the 16th low phase go to HOLD; otherwise go to SHIFT_HI.
  - SHIFT_HI: dac_sclk=1. dac_din updates to the next bit in the same cycle dac_sclk rises. Hold SCLK_DIV cycles, then go to SHIFT_LO.
  - HOLD: dac_sclk=1, sync_n=0 for SCLK_DIV cycles. Then sync_n=1, done=1 for exactly that cycle, dac_din=0, and go to GAP.
  - GAP: sync_n=1 for IDLE_CYCLES cycles, counted from the cycle sync_n rises. Then go to IDLE, where load_ready=1 and busy=0.
- Frame timing:
  - sync_n is low for exactly 33*SCLK_DIV cycles.
  - Exactly 16 dac_sclk falling edges occur per frame.
  - dac_din is stable for ≥SCLK_DIV cycles before each falling edge and SCLK_DIV cycles after it.
  - sync_n falls the cycle after acceptance.
  - Accept-to-accept spacing is at least 1 + 33*SCLK_DIV + IDLE_CYCLES cycles.
- Bit counter is 4 bits and counts 16 falling edges. It must not wrap into a 17th edge.
- Divider counter is sized as $clog2(SCLK_DIV+1) and reloads on every phase change.
- Reset mid-frame:
  - Outputs return to reset values immediately (asynchronous).
  - sync_n rises before the 16th falling edge, so the DAC aborts the write and retains its previous code.
  - No done pulse is produced for an aborted frame.
- Simultaneous events: a done cycle never coincides with load_ready=1 because the gap separates them. load_valid is sampled only in IDLE.

Test Plan:
- Reset: hold rstn=0 → sync_n=1, dac_sclk=1, dac_din=0, load_ready=0, busy=0, done=0. Release → load_ready=1 next cycle.
- Single write, load_data=0xA5, load_pd=00, SCLK_DIV=4 → bits captured on dac_sclk falling edges = 16'h0A50, MSB first. sync_n low exactly 132 cycles, 16 falling edges, done high exactly 1 cycle.
- Power-down write, load_data=0xFF, load_pd=11 → captured frame 16'h3FF0. dac_din stable ≥4 cycles around every falling edge.
- Back-to-back: load_valid held high with load_data=0x12 then 0x34. Change load_data mid-frame → first frame 16'h0120, second 16'h0340. Second acceptance occurs exactly IDLE_CYCLES=100 cycles after sync_n rises.
- Abort: assert rstn=0 after 7 falling edges → sync_n=1 and dac_sclk=1 in the same cycle, no done pulse. After release, a write of 0x80 produces a clean frame 16'h0800.
- Parameter corner: SCLK_DIV=1, IDLE_CYCLES=1, write 0x01 → sync_n low 33 cycles, frame 16'h0010, next acceptance allowed 1 cycle after sync_n rises.
